pc_redirect_ctrl: RTL and testbench

Consumer end of the EX-stage branch-resolution interface: it accepts the PcSel/BrPC redirect request and the Halt indication and owns the fetch PC register. It also generates registered flush pulses for the IF/ID and ID/EX pipeline registers and tracks the halted condition. It sits between the EX-stage branch resolver, the hazard unit (stall) and instruction memory.

---
 rtl/pc_redirect_ctrl_if.sv | 27 ++
 rtl/pc_redirect_ctrl.sv | 111 +++++++++++
 tb/tb_pc_redirect_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/pc_redirect_ctrl_if.sv
// Branch-resolution interface between the EX stage and the fetch PC controller.
// master: EX/hazard side driving redirect requests; slave: pc_redirect_ctrl.
interface pc_redirect_ctrl_if #(
  parameter int unsigned PC_W = 9
) ();
  logic            Stall;
  logic            PcSel;
  logic [31:0]     BrPC;
  logic            Halt;
  logic [PC_W-1:0] Cur_PC;
  logic            IF_ID_Flush;
  logic            ID_EX_Flush;
  logic            Fetch_Valid;
  logic            Halted;
  logic            MisalignErr;
  logic [31:0]     RedirCount;

  modport master (
    output Stall, PcSel, BrPC, Halt,
    input  Cur_PC, IF_ID_Flush, ID_EX_Flush, Fetch_Valid, Halted, MisalignErr, RedirCount
  );

  modport slave (
    input  Stall, PcSel, BrPC, Halt,
    output Cur_PC, IF_ID_Flush, ID_EX_Flush, Fetch_Valid, Halted, MisalignErr, RedirCount
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC owner: accepts EX-stage redirects/halts, generates registered pipeline flushes and
// tracks the halted state. Optional macro REDIRECT_COUNTER_EN enables a saturating count of
// accepted non-halt redirects on RedirCount (tied to 0 when undefined).
module pc_redirect_ctrl #(
  parameter int unsigned     PC_W         = 9,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter int unsigned     FLUSH_CYCLES = 2
) (
  input logic               clk,
  input logic               reset,
  pc_redirect_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StRun, StFlush, StHalted} state_e;

  localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES);

  state_e          r_state, w_state_nxt;
  logic [2:0]      r_flush_cnt, w_flush_cnt_nxt;
  logic [PC_W-1:0] r_pc, w_pc_nxt;
  logic            r_misalign, w_misalign_nxt;
  logic            w_redir_take;

  // Upper target bits are truncated by design.
  logic w_unused_brpc;
  assign w_unused_brpc = ^bus.BrPC[31:PC_W];

  // Next-state: halt beats redirect, redirect beats stall, stall beats increment.
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_pc_nxt        = r_pc;
    w_misalign_nxt  = r_misalign;
    w_redir_take    = 1'b0;
    unique case (r_state)
      StRun, StFlush: begin
        if (bus.PcSel && bus.Halt) begin
          w_state_nxt     = StHalted;
          w_pc_nxt        = bus.BrPC[PC_W-1:0];
          w_flush_cnt_nxt = '0;
        end else if (bus.PcSel) begin
          w_state_nxt     = StFlush;
          w_pc_nxt        = {bus.BrPC[PC_W-1:2], 2'b00};
          w_flush_cnt_nxt = FlushLoad;
          w_misalign_nxt  = r_misalign | (|bus.BrPC[1:0]);
          w_redir_take    = 1'b1;
        end else begin
          if (!bus.Stall) begin
            w_pc_nxt = r_pc + PC_W'(4);
          end
          // Flush window counts down even while stalled.
          if (r_state == StFlush) begin
            w_flush_cnt_nxt = r_flush_cnt - 3'd1;
            if (r_flush_cnt == 3'd1) begin
              w_state_nxt = StRun;
            end
          end
        end
      end
      StHalted: begin
        // Frozen until reset.
      end
      default: begin
        w_state_nxt = StRun;
      end
    endcase
  end

  // State, PC, flush counter and sticky misalign registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StRun;
      r_flush_cnt <= '0;
      r_pc        <= RESET_PC;
      r_misalign  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_pc        <= w_pc_nxt;
      r_misalign  <= w_misalign_nxt;
    end
  end

`ifdef REDIRECT_COUNTER_EN
  logic [31:0] r_redir_cnt;

  // Saturating count of accepted non-halt redirects.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_redir_cnt <= '0;
    end else if (w_redir_take && (r_redir_cnt != 32'hFFFF_FFFF)) begin
      r_redir_cnt <= r_redir_cnt + 32'd1;
    end
  end

  assign bus.RedirCount = r_redir_cnt;
`else
  logic w_unused_take;
  assign w_unused_take  = w_redir_take;
  assign bus.RedirCount = '0;
`endif

  // Outputs come only from registers or decoded state.
  assign bus.Cur_PC      = r_pc;
  assign bus.IF_ID_Flush = (r_state == StFlush);
  assign bus.ID_EX_Flush = (r_state == StFlush);
  assign bus.Fetch_Valid = (r_state == StRun);
  assign bus.Halted      = (r_state == StHalted);
  assign bus.MisalignErr = r_misalign;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: directed test-plan sequence followed by randomized
// redirect/stall/halt/reset traffic, all checked against a cycle-level reference model.
module tb_pc_redirect_ctrl;
  localparam int unsigned PC_W  = 9;
  localparam int unsigned FLUSH = 2;
  localparam int unsigned PC_MOD = 1 << PC_W;

  logic clk;
  logic reset;

  pc_redirect_ctrl_if #(.PC_W(PC_W)) u_if ();

  pc_redirect_ctrl #(
    .PC_W        (PC_W),
    .RESET_PC    ('0),
    .FLUSH_CYCLES(FLUSH)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: PC as an integer, flush as "cycles remaining".
  int unsigned m_pc;
  int unsigned m_flush_left;
  bit          m_halted;
  bit          m_misalign;
  longint unsigned m_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc         = 0;
    m_flush_left = 0;
    m_halted     = 0;
    m_misalign   = 0;
    m_count      = 0;
  endtask

  task automatic model_edge(input bit st, input bit ps, input bit ha, input logic [31:0] br);
    if (m_halted) return;
    if (ps && ha) begin
      m_pc         = br % PC_MOD;
      m_halted     = 1;
      m_flush_left = 0;
    end else if (ps) begin
      m_pc         = (br % PC_MOD) & ~32'd3;
      m_flush_left = FLUSH;
      if (br % 4 != 0) m_misalign = 1;
      if (m_count < 64'hFFFF_FFFF) m_count++;
    end else begin
      if (m_flush_left > 0) m_flush_left--;
      if (!st) m_pc = (m_pc + 4) % PC_MOD;
    end
  endtask

  task automatic check_all();
    logic [31:0] exp_cnt;
`ifdef REDIRECT_COUNTER_EN
    exp_cnt = m_count[31:0];
`else
    exp_cnt = 32'd0;
`endif
    check("cur_pc",      32'(u_if.Cur_PC), m_pc);
    check("if_id_flush", 32'(u_if.IF_ID_Flush), 32'(!m_halted && m_flush_left > 0));
    check("id_ex_flush", 32'(u_if.ID_EX_Flush), 32'(!m_halted && m_flush_left > 0));
    check("fetch_valid", 32'(u_if.Fetch_Valid), 32'(!m_halted && m_flush_left == 0));
    check("halted",      32'(u_if.Halted), 32'(m_halted));
    check("misalign",    32'(u_if.MisalignErr), 32'(m_misalign));
    check("redir_count", u_if.RedirCount, exp_cnt);
  endtask

  // Drive inputs, clock one edge, update model, sample 1 time unit after the edge.
  task automatic step(input bit st, input bit ps, input bit ha, input logic [31:0] br);
    u_if.Stall = st;
    u_if.PcSel = ps;
    u_if.Halt  = ha;
    u_if.BrPC  = br;
    @(posedge clk);
    model_edge(st, ps, ha, br);
    #1;
    check_all();
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    #2;
    reset = 1'b1;
  endtask

  initial begin
    u_if.Stall = 1'b0;
    u_if.PcSel = 1'b0;
    u_if.Halt  = 1'b0;
    u_if.BrPC  = '0;
    reset      = 1'b1;
    @(posedge clk);
    #1;
    apply_reset();

    // Sequential fetch.
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 0, 32'h0);
      check("seq_pc", 32'(u_if.Cur_PC), 32'(4 * i));
    end

    // Redirect with two-cycle flush window.
    step(0, 1, 0, 32'h40);
    check("redir_pc", 32'(u_if.Cur_PC), 32'h40);
    check("redir_flush", 32'(u_if.IF_ID_Flush), 32'd1);
    step(0, 0, 0, 32'h0);
    check("redir_pc1", 32'(u_if.Cur_PC), 32'h44);
    check("redir_flush1", 32'(u_if.ID_EX_Flush), 32'd1);
    step(0, 0, 0, 32'h0);
    check("redir_pc2", 32'(u_if.Cur_PC), 32'h48);
    check("redir_flush2", 32'(u_if.IF_ID_Flush), 32'd0);

    // Redirect beats stall; held stall freezes PC.
    step(1, 1, 0, 32'h80);
    check("stall_redir_pc", 32'(u_if.Cur_PC), 32'h80);
    step(1, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0);
    check("stall_hold_pc", 32'(u_if.Cur_PC), 32'h80);
    check("stall_flush_done", 32'(u_if.Fetch_Valid), 32'd1);

    // Misaligned target, then wrap at the top of the address space.
    step(0, 1, 0, 32'h1F2);
    check("misalign_pc", 32'(u_if.Cur_PC), 32'h1F0);
    check("misalign_set", 32'(u_if.MisalignErr), 32'd1);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 32'h0);
      if (i == 2) check("wrap_top", 32'(u_if.Cur_PC), 32'h1FC);
      if (i == 3) check("wrap_zero", 32'(u_if.Cur_PC), 32'h000);
    end
    check("misalign_sticky", 32'(u_if.MisalignErr), 32'd1);

    // Halt, then ignored redirect, then reset.
    step(0, 1, 1, 32'h24);
    check("halt_pc", 32'(u_if.Cur_PC), 32'h24);
    check("halt_flag", 32'(u_if.Halted), 32'd1);
    check("halt_fv", 32'(u_if.Fetch_Valid), 32'd0);
    step(0, 1, 0, 32'h100);
    check("halt_ignore", 32'(u_if.Cur_PC), 32'h24);
`ifdef REDIRECT_COUNTER_EN
    check("count_three", u_if.RedirCount, 32'd3);
`endif
    apply_reset();
    check("post_halt_pc", 32'(u_if.Cur_PC), 32'h0);
    check("post_halt_flag", 32'(u_if.Halted), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit          st, ps, ha;
      logic [31:0] br;
      st = ($urandom_range(0, 3) == 0);
      ps = ($urandom_range(0, 6) == 0);
      ha = ($urandom_range(0, 40) == 0);
      br = $urandom();
      if ($urandom_range(0, 1) == 0) br[1:0] = 2'b00;
      step(st, ps, ha, br);
      if ($urandom_range(0, 150) == 0 || (m_halted && $urandom_range(0, 20) == 0)) begin
        apply_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
